// File: rtl/vga_text_layer.sv
// vga_text_layer: 100x37 text overlay of 8x16 cells with external font ROM, 16-entry palette and blinking cursor.
// Latency: pixel inputs sampled at edge N reach RGB/sync outputs after edge N+4, including the one-cycle ROM read.
// Backpressure: none; the pipeline advances on every pixel clock and never stalls.

module vga_text_layer #(
  parameter int COLS         = 100,
  parameter int ROWS         = 37,
  parameter int BLINK_FRAMES = 30
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [10:0] pix_x,
  input  logic [9:0]  pix_y,
  input  logic        pix_active,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        wr_en,
  input  logic [11:0] wr_addr,
  input  logic [15:0] wr_data,
  input  logic        pal_we,
  input  logic [3:0]  pal_idx,
  input  logic [11:0] pal_data,
  input  logic        cursor_en,
  input  logic [6:0]  cursor_col,
  input  logic [5:0]  cursor_row,
  output logic [11:0] font_addr,
  input  logic [7:0]  font_data,
  output logic [3:0]  red_out,
  output logic [3:0]  green_out,
  output logic [3:0]  blue_out,
  output logic        hsync_out,
  output logic        vsync_out
);

  localparam int              DEPTH      = COLS * ROWS;
  localparam int              CW         = $clog2(BLINK_FRAMES + 1);
  localparam logic [11:0]     COLS_W     = 12'(COLS);
  localparam logic [11:0]     ROWS_W     = 12'(ROWS);
  localparam logic [11:0]     DEPTH_W    = 12'(DEPTH);
  localparam logic [CW-1:0]   BLINK_LAST = CW'(BLINK_FRAMES - 1);

  // Cursor state, latched only at frame boundaries so a frame never tears.
  logic          cur_en_q;
  logic [6:0]    cur_col_q;
  logic [5:0]    cur_row_q;
  logic [CW-1:0] frame_cnt_q, frame_cnt_d;
  logic          blink_q, blink_d;
  logic          frame_evt;

  // Stage 0 combinational signals
  logic [11:0] col_x, row_x, rd_addr;
  logic        in_rng, hit_d;

  // Pipeline registers, numbered by the edge (N+k) that loads them
  logic        blank0_q, hit0_q, hs0_q, vs0_q;
  logic [2:0]  x0_q;
  logic [3:0]  y0_q;
  logic [15:0] rd_raw_q;
  logic [15:0] rd_dat_q;
  logic        blank1_q, hit1_q, hs1_q, vs1_q;
  logic [2:0]  x1_q;
  logic [3:0]  y1_q;
  logic [11:0] font_addr_q;
  logic [3:0]  fg2_q, bg2_q;
  logic        blank2_q, hit2_q, hs2_q, vs2_q;
  logic [2:0]  x2_q;
  logic [3:0]  fg3_q, bg3_q;
  logic        blank3_q, hit3_q, hs3_q, vs3_q;
  logic [2:0]  x3_q;
  logic [11:0] rgb_q, rgb_d;
  logic        hs4_q, vs4_q;

  logic [11:0] pal_q [16];
  logic [15:0] buf_mem [DEPTH];
  logic        pix_bit;
  logic [3:0]  col_idx;

  // Cell address, blank tag and cursor match for the incoming pixel.
  always_comb begin
    col_x   = {4'd0, pix_x[10:3]};
    row_x   = {6'd0, pix_y[9:4]};
    in_rng  = pix_active && (col_x < COLS_W) && (row_x < ROWS_W);
    rd_addr = in_rng ? (row_x * COLS_W + col_x) : 12'd0;
    hit_d   = cur_en_q && blink_q
              && (col_x == {5'd0, cur_col_q})
              && (row_x == {6'd0, cur_row_q})
              && (pix_y[3:1] == 3'b111);
  end

  // Character buffer: single write port, read-first synchronous read, contents not reset.
  always_ff @(posedge clk) begin
    if (wr_en && (wr_addr < DEPTH_W)) begin
      buf_mem[wr_addr] <= wr_data;
    end
    rd_raw_q <= buf_mem[rd_addr];
  end

  // Frame event on the falling edge of the registered vsync.
  assign frame_evt = vs1_q & ~vs0_q;

  // Blink counter next state: wrap at BLINK_FRAMES-1 and toggle the phase.
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    blink_d     = blink_q;
    if (frame_evt) begin
      if (frame_cnt_q == BLINK_LAST) begin
        frame_cnt_d = '0;
        blink_d     = ~blink_q;
      end else begin
        frame_cnt_d = frame_cnt_q + CW'(1);
      end
    end
  end

  // Blink counter and cursor latch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt_q <= '0;
      blink_q     <= 1'b0;
      cur_en_q    <= 1'b0;
      cur_col_q   <= '0;
      cur_row_q   <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      blink_q     <= blink_d;
      if (frame_evt) begin
        cur_en_q  <= cursor_en;
        cur_col_q <= cursor_col;
        cur_row_q <= cursor_row;
      end
    end
  end

  // Side-band pipeline plus buffer data and font address registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blank0_q <= 1'b1; hit0_q <= 1'b0; hs0_q <= 1'b1; vs0_q <= 1'b1;
      x0_q <= '0; y0_q <= '0;
      rd_dat_q <= '0;
      blank1_q <= 1'b1; hit1_q <= 1'b0; hs1_q <= 1'b1; vs1_q <= 1'b1;
      x1_q <= '0; y1_q <= '0;
      font_addr_q <= '0; fg2_q <= '0; bg2_q <= '0;
      blank2_q <= 1'b1; hit2_q <= 1'b0; hs2_q <= 1'b1; vs2_q <= 1'b1;
      x2_q <= '0;
      fg3_q <= '0; bg3_q <= '0;
      blank3_q <= 1'b1; hit3_q <= 1'b0; hs3_q <= 1'b1; vs3_q <= 1'b1;
      x3_q <= '0;
    end else begin
      blank0_q <= ~in_rng; hit0_q <= hit_d; hs0_q <= hsync_in; vs0_q <= vsync_in;
      x0_q <= pix_x[2:0]; y0_q <= pix_y[3:0];
      rd_dat_q <= rd_raw_q;
      blank1_q <= blank0_q; hit1_q <= hit0_q; hs1_q <= hs0_q; vs1_q <= vs0_q;
      x1_q <= x0_q; y1_q <= y0_q;
      font_addr_q <= {rd_dat_q[7:0], y1_q};
      fg2_q <= rd_dat_q[11:8]; bg2_q <= rd_dat_q[15:12];
      blank2_q <= blank1_q; hit2_q <= hit1_q; hs2_q <= hs1_q; vs2_q <= vs1_q;
      x2_q <= x1_q;
      fg3_q <= fg2_q; bg3_q <= bg2_q;
      blank3_q <= blank2_q; hit3_q <= hit2_q; hs3_q <= hs2_q; vs3_q <= vs2_q;
      x3_q <= x2_q;
    end
  end

  // Pixel colour: glyph bit XOR cursor picks fg or bg; blank pixels are black.
  always_comb begin
    pix_bit = font_data[~x3_q];
    col_idx = (pix_bit ^ hit3_q) ? fg3_q : bg3_q;
    rgb_d   = blank3_q ? 12'h000 : pal_q[col_idx];
  end

  // Palette storage; a write is visible to lookups from the following cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) begin
        pal_q[i] <= {4'(i), 4'(i), 4'(i)};
      end
    end else if (pal_we) begin
      pal_q[pal_idx] <= pal_data;
    end
  end

  // Output registers for colour and delayed syncs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rgb_q <= '0;
      hs4_q <= 1'b1;
      vs4_q <= 1'b1;
    end else begin
      rgb_q <= rgb_d;
      hs4_q <= hs3_q;
      vs4_q <= vs3_q;
    end
  end

  assign font_addr = font_addr_q;
  assign red_out   = rgb_q[11:8];
  assign green_out = rgb_q[7:4];
  assign blue_out  = rgb_q[3:0];
  assign hsync_out = hs4_q;
  assign vsync_out = vs4_q;

endmodule

// File: tb/tb_vga_text_layer.sv
module tb_vga_text_layer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [10:0] pix_x;
  logic [9:0]  pix_y;
  logic        pix_active, hsync_in, vsync_in;
  logic        wr_en;
  logic [11:0] wr_addr;
  logic [15:0] wr_data;
  logic        pal_we;
  logic [3:0]  pal_idx;
  logic [11:0] pal_data;
  logic        cursor_en;
  logic [6:0]  cursor_col;
  logic [5:0]  cursor_row;
  logic [11:0] font_addr;
  logic [7:0]  font_data = 8'h00;
  logic [3:0]  red_out, green_out, blue_out;
  logic        hsync_out, vsync_out;
  logic [11:0] rgb;

  int checks = 0;
  int errors = 0;

  vga_text_layer #(.COLS(100), .ROWS(37), .BLINK_FRAMES(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .pix_x(pix_x), .pix_y(pix_y), .pix_active(pix_active),
    .hsync_in(hsync_in), .vsync_in(vsync_in),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .pal_we(pal_we), .pal_idx(pal_idx), .pal_data(pal_data),
    .cursor_en(cursor_en), .cursor_col(cursor_col), .cursor_row(cursor_row),
    .font_addr(font_addr), .font_data(font_data),
    .red_out(red_out), .green_out(green_out), .blue_out(blue_out),
    .hsync_out(hsync_out), .vsync_out(vsync_out)
  );

  always #5 clk = ~clk;
  assign rgb = {red_out, green_out, blue_out};

  // Font ROM model: 'A' row 0 = 80, 'B' = F0, 'C' = 0F, 'D' = FF on every row.
  function automatic logic [7:0] rom_f(input logic [11:0] a);
    case (a[11:4])
      8'h41:   rom_f = (a[3:0] == 4'd0) ? 8'h80 : 8'h00;
      8'h42:   rom_f = 8'hF0;
      8'h43:   rom_f = 8'h0F;
      8'h44:   rom_f = 8'hFF;
      default: rom_f = 8'h00;
    endcase
  endfunction

  always @(posedge clk) font_data <= rom_f(font_addr);

  typedef struct {
    string       name;
    logic [10:0] x;
    logic [9:0]  y;
    logic        act;
    logic        hs;
    logic        vs;
    logic [11:0] exp_rgb;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic idle();
    pix_x = '0; pix_y = '0; pix_active = 1'b0; hsync_in = 1'b1; vsync_in = 1'b1;
  endtask

  task automatic drive(input logic [10:0] x, input logic [9:0] y, input logic act);
    pix_x = x; pix_y = y; pix_active = act;
  endtask

  task automatic wr_cell(input logic [11:0] a, input logic [15:0] d);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic wr_pal(input logic [3:0] i, input logic [11:0] d);
    @(negedge clk);
    pal_we = 1'b1; pal_idx = i; pal_data = d;
    @(negedge clk);
    pal_we = 1'b0;
  endtask

  // One isolated pixel: idle before and after; output must be idle at N+3 and expected at N+4.
  task automatic pix_test(input string nm, input logic [10:0] x, input logic [9:0] y,
                          input logic act, input logic hs, input logic vs, input logic [11:0] exp);
    idle();
    repeat (5) @(negedge clk);
    drive(x, y, act); hsync_in = hs; vsync_in = vs;
    @(negedge clk);
    idle();
    repeat (3) @(negedge clk);
    chk({nm, "_early"}, rgb, 12'h000);
    @(negedge clk);
    chk(nm, rgb, exp);
    chk({nm, "_hs"}, hsync_out, hs);
    chk({nm, "_vs"}, vsync_out, vs);
  endtask

  task automatic frame();
    @(negedge clk);
    vsync_in = 1'b0;
    repeat (3) @(negedge clk);
    vsync_in = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    vecs[0]  = '{"px_0_0",     11'd0,    10'd0,    1'b1, 1'b1, 1'b1, 12'hFFF};
    vecs[1]  = '{"px_1_0",     11'd1,    10'd0,    1'b1, 1'b1, 1'b1, 12'h000};
    vecs[2]  = '{"px_8_0",     11'd8,    10'd0,    1'b1, 1'b1, 1'b1, 12'hCCC};
    vecs[3]  = '{"px_12_5",    11'd12,   10'd5,    1'b1, 1'b1, 1'b1, 12'h333};
    vecs[4]  = '{"px_800_0",   11'd800,  10'd0,    1'b1, 1'b1, 1'b1, 12'h000};
    vecs[5]  = '{"px_0_592",   11'd0,    10'd592,  1'b1, 1'b1, 1'b1, 12'h000};
    vecs[6]  = '{"px_inact",   11'd0,    10'd0,    1'b0, 1'b1, 1'b1, 12'h000};
    vecs[7]  = '{"px_792_576", 11'd792,  10'd576,  1'b1, 1'b1, 1'b1, 12'h777};
    vecs[8]  = '{"px_799_591", 11'd799,  10'd591,  1'b1, 1'b1, 1'b1, 12'h777};
    vecs[9]  = '{"px_max",     11'd2047, 10'd1023, 1'b1, 1'b1, 1'b1, 12'h000};
    vecs[10] = '{"px_syncs",   11'd0,    10'd0,    1'b1, 1'b0, 1'b0, 12'hFFF};

    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    pal_we = 1'b0; pal_idx = '0; pal_data = '0;
    cursor_en = 1'b0; cursor_col = '0; cursor_row = '0;

    // Reset held while an active pixel with low syncs is presented.
    rst_n = 1'b0;
    drive(11'd0, 10'd0, 1'b1); hsync_in = 1'b0; vsync_in = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("reset_state", {rgb, hsync_out, vsync_out, font_addr}, {12'h000, 1'b1, 1'b1, 12'h000});
    end
    idle();
    @(negedge clk);
    rst_n = 1'b1;

    // Buffer and palette setup.
    wr_cell(12'd0,    16'h0F41);
    wr_cell(12'd1,    16'h3C42);
    wr_cell(12'd2,    16'h0F44);
    wr_cell(12'd5,    16'h0F41);
    wr_cell(12'd302,  16'h0F42);
    wr_cell(12'd3699, 16'hA744);
    wr_cell(12'd3700, 16'h1143);
    wr_pal(4'd15, 12'hFFF);
    wr_pal(4'd0,  12'h000);

    // Font address for cell 0 at glyph row 0 appears after edge N+2.
    idle();
    repeat (5) @(negedge clk);
    drive(11'd0, 10'd0, 1'b1);
    @(negedge clk);
    idle();
    @(negedge clk);
    @(negedge clk);
    chk("font_addr", font_addr, 12'h410);

    for (int i = 0; i < 11; i++) begin
      pix_test(vecs[i].name, vecs[i].x, vecs[i].y, vecs[i].act, vecs[i].hs, vecs[i].vs, vecs[i].exp_rgb);
    end

    // Read-first collision on cell 5: old 'A' shows now, new 'C' on the next scanline.
    idle();
    repeat (5) @(negedge clk);
    drive(11'd40, 10'd0, 1'b1);
    wr_en = 1'b1; wr_addr = 12'd5; wr_data = 16'h0F43;
    @(negedge clk);
    wr_en = 1'b0;
    idle();
    repeat (4) @(negedge clk);
    chk("collide_old", rgb, 12'hFFF);
    pix_test("collide_new", 11'd44, 10'd1, 1'b1, 1'b1, 1'b1, 12'hFFF);

    // Mid-frame reset drops outputs at once; valid output resumes 4 cycles after release.
    idle();
    drive(11'd0, 10'd0, 1'b1);
    repeat (6) @(negedge clk);
    chk("pre_rst", rgb, 12'hFFF);
    rst_n = 1'b0;
    #1;
    chk("rst_async", {rgb, font_addr}, {12'h000, 12'h000});
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("rst_resume_early", rgb, 12'h000);
    @(negedge clk);
    chk("rst_resume", rgb, 12'hFFF);

    // Cursor blink with BLINK_FRAMES=2 at cell (2,3).
    idle();
    cursor_en = 1'b1; cursor_col = 7'd2; cursor_row = 6'd3;
    frame();
    pix_test("cur_ev1", 11'd16, 10'd62, 1'b1, 1'b1, 1'b1, 12'hFFF);
    frame();
    pix_test("cur_ev2_r14", 11'd16, 10'd62, 1'b1, 1'b1, 1'b1, 12'h000);
    pix_test("cur_ev2_r15", 11'd20, 10'd63, 1'b1, 1'b1, 1'b1, 12'hFFF);
    pix_test("cur_ev2_r13", 11'd16, 10'd61, 1'b1, 1'b1, 1'b1, 12'hFFF);
    cursor_row = 6'd4;
    pix_test("cur_midframe", 11'd16, 10'd62, 1'b1, 1'b1, 1'b1, 12'h000);
    frame();
    pix_test("cur_ev3_moved", 11'd16, 10'd62, 1'b1, 1'b1, 1'b1, 12'hFFF);
    cursor_row = 6'd3;
    frame();
    pix_test("cur_ev4", 11'd16, 10'd62, 1'b1, 1'b1, 1'b1, 12'hFFF);
    frame();
    frame();
    pix_test("cur_ev6", 11'd16, 10'd62, 1'b1, 1'b1, 1'b1, 12'h000);

    // Palette write mid-line: pixels 0..2 use old FFF, pixels 3..7 use F00.
    cursor_en = 1'b0;
    frame();
    idle();
    repeat (5) @(negedge clk);
    for (int t = 0; t <= 12; t++) begin
      @(negedge clk);
      if (t >= 5) chk("pal_midline", rgb, (t - 5 <= 2) ? 12'hFFF : 12'hF00);
      if (t < 8) drive(11'(16 + t), 10'd0, 1'b1);
      else idle();
      pal_we = (t == 6); pal_idx = 4'd15; pal_data = 12'hF00;
    end
    pal_we = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
